// File: rtl/rx_rsp_sched.sv
// rx_rsp_sched: round-robin response scheduler for the RX path.
// Counts outstanding operations per switch instance, picks one eligible switch
// at a time, and presents its captured read data on a single valid/ready port.
// The one-cycle ack pulse it returns also pops that switch's op-id FIFO.
module rx_rsp_sched #(
    parameter int NUM_SW_INST = 5,
    parameter int W_WIDTH     = 8,
    parameter int FIFO_SIZE   = 2,
    parameter int IDX_W       = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_SW_INST-1:0]         sel_en,
    input  logic [NUM_SW_INST-1:0]         rsp_valid,
    input  logic [NUM_SW_INST*W_WIDTH-1:0] rd_data,
    input  logic                           out_ready,
    output logic [NUM_SW_INST-1:0]         ack,
    output logic                           out_valid,
    output logic [W_WIDTH-1:0]             rd_data_out,
    output logic [IDX_W-1:0]               grant_idx,
    output logic [NUM_SW_INST-1:0]         sw_busy,
    output logic [NUM_SW_INST-1:0]         sw_full,
    output logic                           err
);

    localparam int                     CNT_W    = $clog2(FIFO_SIZE + 1);
    localparam logic [CNT_W-1:0]       CNT_FULL = CNT_W'(FIFO_SIZE);
    localparam logic [CNT_W-1:0]       CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W:0]         NUM_W    = (IDX_W + 1)'(NUM_SW_INST);
    localparam logic [IDX_W:0]         START_ONE = (IDX_W + 1)'(1);
    localparam logic [IDX_W-1:0]       PTR_RST  = IDX_W'(NUM_SW_INST - 1);
    localparam logic [NUM_SW_INST-1:0] ACK_ONE  = NUM_SW_INST'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ACK   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [IDX_W-1:0]     grant_idx_q, grant_idx_d;
    logic [W_WIDTH-1:0]   data_q, data_d;
    logic                 err_q, err_d;

    logic                 capture;
    logic [NUM_SW_INST-1:0] eligible;
    logic [NUM_SW_INST-1:0] overflow;
    logic [NUM_SW_INST-1:0] orphan;
    logic [W_WIDTH-1:0]   rd_slice [NUM_SW_INST];

    // Round-robin search scratch
    logic [2*NUM_SW_INST-1:0] elig_dbl;
    logic [NUM_SW_INST-1:0]   elig_rot;
    logic [IDX_W:0]           search_start;
    logic [IDX_W:0]           search_off;
    logic [IDX_W:0]           search_sum;
    logic                     search_found;
    logic [IDX_W-1:0]         pick_idx;
    logic [W_WIDTH-1:0]       pick_data;

    // ------------------------------------------------------------------
    // Per-switch outstanding counters, status flags and error sources
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_SW_INST; gi++) begin : g_sw
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             busy_q, full_q;
        logic             ovf_l;

        // Next count: +1 on dispatch, -1 on ack, unchanged when both coincide;
        // a dispatch into a full counter is dropped and reported.
        always_comb begin
            cnt_d = cnt_q;
            ovf_l = 1'b0;
            if (sel_en[gi] && !ack[gi]) begin
                if (cnt_q == CNT_FULL) begin
                    ovf_l = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end else if (ack[gi] && !sel_en[gi] && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end

        // Counter plus registered busy/full views of its next value
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q  <= '0;
                busy_q <= 1'b0;
                full_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                busy_q <= (cnt_d != '0);
                full_q <= (cnt_d == CNT_FULL);
            end
        end

        // A response is only grantable when an operation is actually pending.
        // A dispatch arriving together with the response excuses it from the
        // orphan check; it becomes eligible once the counter has caught up.
        assign eligible[gi] = rsp_valid[gi] && (cnt_q != '0);
        assign orphan[gi]   = rsp_valid[gi] && (cnt_q == '0) && !sel_en[gi];
        assign overflow[gi] = ovf_l;
        assign sw_busy[gi]  = busy_q;
        assign sw_full[gi]  = full_q;
        assign rd_slice[gi] = rd_data[gi*W_WIDTH +: W_WIDTH];
    end

    // ------------------------------------------------------------------
    // Round-robin selection
    // ------------------------------------------------------------------
    // Rotate the eligible mask so the slot after the last grant sits at bit 0,
    // take the lowest set bit, then map the offset back to a switch index.
    always_comb begin
        search_start = {1'b0, ptr_q} + START_ONE;
        elig_dbl     = {eligible, eligible};
        elig_rot     = NUM_SW_INST'(elig_dbl >> search_start);
        search_found = 1'b0;
        search_off   = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (!search_found && elig_rot[i]) begin
                search_found = 1'b1;
                search_off   = (IDX_W + 1)'(i);
            end
        end
        search_sum = search_start + search_off;
        if (search_sum >= NUM_W) begin
            search_sum = search_sum - NUM_W;
        end
        pick_idx  = search_sum[IDX_W-1:0];
        pick_data = '0;
        for (int i = 0; i < NUM_SW_INST; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_data = rd_slice[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Grant FSM
    // ------------------------------------------------------------------
    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs. While in GRANT nothing else is
    // considered, so the presented data never changes under backpressure.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        out_valid = 1'b0;
        ack       = '0;
        case (state_q)
            ST_IDLE: begin
                if (search_found) begin
                    capture = 1'b1;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ack     = ACK_ONE << grant_idx_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured response, pointer and sticky error
    // ------------------------------------------------------------------
    // Load data, index and pointer only at the moment of a new grant
    always_comb begin
        ptr_d       = ptr_q;
        grant_idx_d = grant_idx_q;
        data_d      = data_q;
        if (capture) begin
            ptr_d       = pick_idx;
            grant_idx_d = pick_idx;
            data_d      = pick_data;
        end
        err_d = err_q | (|overflow) | (|orphan);
    end

    // Datapath registers; the pointer resets to the last index so switch 0
    // is the first candidate after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q       <= PTR_RST;
            grant_idx_q <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            grant_idx_q <= grant_idx_d;
            data_q      <= data_d;
            err_q       <= err_d;
        end
    end

    assign rd_data_out = data_q;
    assign grant_idx   = grant_idx_q;
    assign err         = err_q;

endmodule

// File: doc/rx_rsp_sched.md
# rx_rsp_sched

Round-robin response scheduler for the RX path. It tracks how many operations are outstanding at each switch instance and picks one ready switch at a time. It drives that switch's read data to the single shared RX output with a valid/ready handshake, then returns a one-cycle `ack` pulse to the switch. It sits between the switch instances and the RX op-id FIFOs/mux: its `ack` is the same pulse that pops the per-switch op-id FIFO.

## Interface
Parameters:
- `NUM_SW_INST`, 5: number of switch instances (2..16).
- `W_WIDTH`, 8: read-data width.
- `FIFO_SIZE`, 2: maximum outstanding operations per switch. Must match the per-switch op-id FIFO depth.
- `IDX_W`, 3: grant-index width, ≥ clog2(NUM_SW_INST).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `sel_en` in NUM_SW_INST: bit i = one operation dispatched to switch i this cycle.
- `rsp_valid` in NUM_SW_INST: bit i = switch i presents completed read data.
- `rd_data` in NUM_SW_INST*W_WIDTH: switch i data in bits [(i+1)*W_WIDTH-1 : i*W_WIDTH].
- `out_ready` in 1: downstream accepts `rd_data_out`.
- `ack` out NUM_SW_INST: one-hot, one-cycle pulse to the granted switch.
- `out_valid` out 1: `rd_data_out` and `grant_idx` are valid.
- `rd_data_out` out W_WIDTH: captured data of the granted switch.
- `grant_idx` out IDX_W: index of the granted switch.
- `sw_busy` out NUM_SW_INST: bit i = outstanding count of switch i is non-zero.
- `sw_full` out NUM_SW_INST: bit i = outstanding count of switch i equals FIFO_SIZE.
- `err` out 1: sticky protocol-error flag.

## Operation
- **Outstanding counter per switch** (`cnt[i]`, width clog2(FIFO_SIZE+1)), updated every cycle:
  - +1 on `sel_en[i]`, −1 on `ack[i]`.
  - Both in the same cycle: the count is unchanged.
  - `sel_en[i]` while `cnt[i]==FIFO_SIZE` with no `ack[i]`: the increment is dropped and `err` is set.
- **Eligibility:** switch i is eligible when `rsp_valid[i] && cnt[i]!=0`.
  - `rsp_valid[i]` with `cnt[i]==0` sets `err`, and the switch is never granted.
- **Round-robin pointer** `ptr` holds the last granted index. The search starts at `ptr+1`, wraps modulo NUM_SW_INST, and takes the first eligible switch.
- **FSM:**
  - **IDLE:** if any switch is eligible, capture its `rd_data` slice into `rd_data_out`, set `grant_idx`, set `ptr`, and go to GRANT. Otherwise stay in IDLE.
  - **GRANT:** `out_valid=1`; data and index are held stable. When `out_ready=1`, go to ACK. Otherwise stay; there is no timeout, and other switches are not considered.
  - **ACK:** `ack[grant_idx]=1` for exactly this cycle, `out_valid=0`, the counter is decremented, then go to IDLE.
- **`err`** is sticky until reset.
- **Reset values:** `ack=0`, `out_valid=0`, `rd_data_out=0`, `grant_idx=0`, `sw_busy=0`, `sw_full=0`, `err=0`, all `cnt=0`, `ptr=NUM_SW_INST-1` (so index 0 wins first), FSM in IDLE.
- **Reset mid-operation:** a pending grant is abandoned and no `ack` is issued. Outputs reach their reset values asynchronously.

## Timing
- Eligible switch seen in IDLE at cycle T → `out_valid=1` from cycle T+1.
- `out_ready` sampled high at cycle G → `ack` high during cycle G+1, `out_valid` low in G+1 → IDLE in G+2.
- Minimum spacing is 3 cycles per response; this is the maximum throughput.
- `sw_busy` and `sw_full` are registered: they reflect the counters one cycle after `sel_en` or `ack`.
- `sel_en[i]` and `rsp_valid[i]` both asserted in the same cycle with `cnt[i]==0`: the switch is not eligible that cycle and no error is flagged, because the counter is already incremented at the clock edge. It becomes eligible the next cycle.
- `rsp_valid` may drop while a switch is in GRANT. The captured data is still delivered and acked.

## Test plan
- **Single switch:**
  - Stimulus: `sel_en=5'b00100`; two cycles later `rsp_valid[2]=1`, `rd_data` slice 2 = 8'hA5, `out_ready=1`.
  - Required: `out_valid` with `rd_data_out=8'hA5`, `grant_idx=2`; `ack=5'b00100` for one cycle; `sw_busy[2]` returns to 0.
- **Round-robin fairness:**
  - Stimulus: all five switches busy with `rsp_valid=5'b11111` held; each switch holds two outstanding ops.
  - Required: grant order 0,1,2,3,4,0,1,2,3,4, with `ack` pulses exactly 3 cycles apart.
- **Backpressure:**
  - Stimulus: `out_ready=0` for 10 cycles during GRANT, with data changing on the `rd_data` inputs.
  - Required: `rd_data_out` and `grant_idx` stay stable, `ack=0`; the ack arrives one cycle after `out_ready` rises.
- **Full and error:**
  - Stimulus: three `sel_en[1]` pulses with FIFO_SIZE=2, then `rsp_valid[3]=1` with `cnt[3]=0`.
  - Required: `sw_full[1]=1` and `cnt[1]=2`; `err=1` stays set; switch 3 is never acked.
- **Simultaneous events:**
  - Stimulus: `sel_en[0]` in the same cycle as `ack[0]` at `cnt[0]=2`.
  - Required: `cnt[0]` stays 2 and `sw_full[0]` stays 1, with no error.
- **Reset mid-GRANT:**
  - Stimulus: assert `rst` while `out_valid=1`.
  - Required: all outputs 0 immediately; the first grant after reset goes to the lowest eligible index.
